// File: rtl/wb_mem_ctrl.sv
// Write-back stage data-memory sequencer: req/gnt/rvalid handshake, load alignment and the register-file write port.
// Optional watchdog abort is built when WB_MEM_TIMEOUT_EN is defined.
module wb_mem_ctrl #(
   parameter int WORD_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 5,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            load_type_i,
   input  logic [1:0]            store_type_i,
   input  logic                  write_en_i,
   input  logic [WORD_WIDTH-1:0] wb_data_i,
   input  logic [WORD_WIDTH-1:0] store_data_i,
   input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
   output logic                  stall_o,
   output logic                  data_req_o,
   output logic                  data_we_o,
   output logic [3:0]            data_be_o,
   output logic [WORD_WIDTH-1:0] data_addr_o,
   output logic [WORD_WIDTH-1:0] data_wdata_o,
   input  logic                  data_gnt_i,
   input  logic                  data_rvalid_i,
   input  logic [WORD_WIDTH-1:0] data_rdata_i,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [WORD_WIDTH-1:0] rf_wdata_o,
   output logic                  misaligned_o,
   output logic                  bus_error_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_load_data;
   logic              w_is_store;
   logic              w_is_load;
   logic              w_mem_op;
   logic              w_misaligned;
   logic              w_signed;
   logic [1:0]        w_size;
   logic [1:0]        w_off;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic [31:0]       w_load_fmt;
   logic              w_timeout;
   logic              w_abort;

   assign w_off = wb_data_i[1:0];

   // Decode access kind and size (0 byte, 1 half, 2 word); a store field overrides the load field.
   always_comb begin
      w_is_store = (store_type_i != 2'b00);
      w_is_load  = 1'b0;
      w_signed   = 1'b0;
      w_size     = 2'd2;
      if (w_is_store) begin
         case (store_type_i)
            2'b01:   w_size = 2'd0;
            2'b10:   w_size = 2'd1;
            default: w_size = 2'd2;
         endcase
      end else begin
         case (load_type_i)
            3'b001:  begin w_is_load = 1'b1; w_size = 2'd0; w_signed = 1'b1; end
            3'b010:  begin w_is_load = 1'b1; w_size = 2'd1; w_signed = 1'b1; end
            3'b011:  begin w_is_load = 1'b1; w_size = 2'd2; end
            3'b101:  begin w_is_load = 1'b1; w_size = 2'd0; end
            3'b110:  begin w_is_load = 1'b1; w_size = 2'd1; end
            default: w_is_load = 1'b0;
         endcase
      end
      w_mem_op     = w_is_store | w_is_load;
      w_misaligned = w_mem_op && (((w_size == 2'd1) && w_off[0]) ||
                                  ((w_size == 2'd2) && (w_off != 2'b00)));
   end

   // Byte enables, lane-replicated store data and sign/zero-extended load data.
   always_comb begin
      case (w_size)
         2'd0: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{store_data_i[7:0]}};
         end
         2'd1: begin
            w_be    = 4'b0011 << {w_off[1], 1'b0};
            w_wdata = {2{store_data_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = store_data_i;
         end
      endcase
      case (w_off)
         2'd0:    w_byte = data_rdata_i[7:0];
         2'd1:    w_byte = data_rdata_i[15:8];
         2'd2:    w_byte = data_rdata_i[23:16];
         default: w_byte = data_rdata_i[31:24];
      endcase
      w_half = w_off[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
      case (w_size)
         2'd0:    w_load_fmt = w_signed ? {{24{w_byte[7]}}, w_byte} : {24'h000000, w_byte};
         2'd1:    w_load_fmt = w_signed ? {{16{w_half[15]}}, w_half} : {16'h0000, w_half};
         default: w_load_fmt = data_rdata_i;
      endcase
   end

`ifdef WB_MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_abort;

   // The issue cycle in IDLE counts toward the budget, so the abort fires TIMEOUT_CYCLES cycles after issue.
   assign w_timeout = (((r_state == S_REQ) && !data_gnt_i) ||
                       ((r_state == S_WAIT) && !data_rvalid_i)) && (r_cnt >= CNT_LIMIT);
   assign w_abort   = r_abort;

   // Saturating watchdog, cleared while IDLE; abort flag marks the DONE that follows a timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_abort <= 1'b0;
      end else begin
         r_abort <= w_timeout;
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
         end else if (((r_state == S_REQ) || (r_state == S_WAIT)) && (r_cnt != CNT_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_abort   = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Load-data capture on the read response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_data <= 32'h0000_0000;
      end else if ((r_state == S_WAIT) && data_rvalid_i) begin
         r_load_data <= w_load_fmt;
      end
   end

   // Next-state and outputs; everything is held at zero while rst is high.
   always_comb begin
      w_next       = r_state;
      stall_o      = 1'b0;
      data_req_o   = 1'b0;
      data_we_o    = 1'b0;
      data_be_o    = 4'b0000;
      data_addr_o  = '0;
      data_wdata_o = '0;
      rf_we_o      = 1'b0;
      rf_waddr_o   = '0;
      rf_wdata_o   = '0;
      misaligned_o = 1'b0;
      bus_error_o  = 1'b0;
      if (rst) begin
         w_next = S_IDLE;
      end else begin
         rf_waddr_o = reg_waddr_i;
         if (w_mem_op) begin
            data_we_o    = w_is_store;
            data_be_o    = w_be;
            data_addr_o  = {wb_data_i[31:2], 2'b00};
            data_wdata_o = w_wdata;
         end else begin
            data_we_o = 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (!w_mem_op) begin
                  rf_we_o    = write_en_i;
                  rf_wdata_o = wb_data_i;
               end else if (w_misaligned) begin
                  misaligned_o = 1'b1;
               end else begin
                  data_req_o = 1'b1;
                  stall_o    = 1'b1;
                  w_next     = data_gnt_i ? S_WAIT : S_REQ;
               end
            end
            S_REQ: begin
               stall_o = 1'b1;
               if (w_timeout) begin
                  bus_error_o = 1'b1;
                  w_next      = S_DONE;
               end else begin
                  data_req_o = 1'b1;
                  w_next     = data_gnt_i ? S_WAIT : S_REQ;
               end
            end
            S_WAIT: begin
               stall_o = 1'b1;
               if (w_timeout) begin
                  bus_error_o = 1'b1;
                  w_next      = S_DONE;
               end else if (data_rvalid_i) begin
                  w_next = S_DONE;
               end else begin
                  w_next = S_WAIT;
               end
            end
            S_DONE: begin
               w_next = S_IDLE;
               if (w_is_load && !w_abort) begin
                  rf_we_o    = write_en_i;
                  rf_wdata_o = r_load_data;
               end else begin
                  rf_we_o = 1'b0;
               end
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_mem_ctrl.sv
// Self-checking bench for wb_mem_ctrl: vector table, directed handshake sequences and randomized accesses.
module tb_wb_mem_ctrl;

`ifdef WB_MEM_TIMEOUT_EN
   localparam int TMO      = 4;
   localparam int MAX_PEND = 3;
`else
   localparam int TMO      = 64;
   localparam int MAX_PEND = 6;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  load_type_i;
   logic [1:0]  store_type_i;
   logic        write_en_i;
   logic [31:0] wb_data_i;
   logic [31:0] store_data_i;
   logic [4:0]  reg_waddr_i;
   logic        stall_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;
   logic        rf_we_o;
   logic [4:0]  rf_waddr_o;
   logic [31:0] rf_wdata_o;
   logic        misaligned_o;
   logic        bus_error_o;

   int checks   = 0;
   int failures = 0;

   wb_mem_ctrl #(.WORD_WIDTH(32), .ADDR_WIDTH(5), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .load_type_i(load_type_i), .store_type_i(store_type_i), .write_en_i(write_en_i),
      .wb_data_i(wb_data_i), .store_data_i(store_data_i), .reg_waddr_i(reg_waddr_i),
      .stall_o(stall_o), .data_req_o(data_req_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
      .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
      .misaligned_o(misaligned_o), .bus_error_o(bus_error_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  lt;
      logic [1:0]  st;
      logic        we;
      logic [31:0] wbd;
      logic [4:0]  wa;
      logic        exp_rf_we;
      logic        exp_mis;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [2:0] lt, input logic [1:0] st, input logic we,
                            input logic [31:0] wbd, input logic [31:0] sd, input logic [4:0] wa);
      load_type_i  = lt;
      store_type_i = st;
      write_en_i   = we;
      wb_data_i    = wbd;
      store_data_i = sd;
      reg_waddr_i  = wa;
   endtask

   // Reference model: access size in bytes from the opcode fields (0 = no memory access).
   function automatic int m_size(input logic [2:0] lt, input logic [1:0] st);
      if (st != 2'b00) return (st == 2'b01) ? 1 : ((st == 2'b10) ? 2 : 4);
      if (lt == 3'b001 || lt == 3'b101) return 1;
      if (lt == 3'b010 || lt == 3'b110) return 2;
      if (lt == 3'b011) return 4;
      return 0;
   endfunction

   function automatic logic [3:0] m_be(input int n, input logic [31:0] addr);
      logic [7:0] t;
      t = ((8'd1 << n) - 8'd1) << (addr % 4);
      return t[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input int n, input logic [31:0] sd);
      logic [31:0] r;
      r = 32'h0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input int n, input logic sgn, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] mask;
      logic [31:0] v;
      int          bits;
      if (n == 4) return rdata;
      bits = 8 * n;
      mask = (32'd1 << bits) - 32'd1;
      v    = (rdata >> (8 * (addr % 4))) & mask;
      if (sgn && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   // Drives one aligned memory access through request, response and DONE; caller is 1 time unit past an edge.
   task automatic mem_access(input logic [2:0] lt, input logic [1:0] st, input logic we,
                             input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wa,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata, input logic exp_dwe,
                             input logic exp_rf_we, input logic [31:0] exp_rf_wdata);
      set_instr(lt, st, we, addr, sd, wa);
      for (int i = 0; i <= gnt_dly; i++) begin
         data_gnt_i = (i == gnt_dly);
         @(negedge clk);
         chk("req_high", data_req_o, 1'b1);
         chk("req_stall", stall_o, 1'b1);
         chk("req_be", data_be_o, exp_be);
         chk("req_addr", data_addr_o, {addr[31:2], 2'b00});
         chk("req_we", data_we_o, exp_dwe);
         if (exp_dwe) chk("req_wdata", data_wdata_o, exp_wdata);
         next_cycle();
      end
      data_gnt_i = 1'b0;
      for (int i = 1; i <= rv_dly; i++) begin
         data_rvalid_i = (i == rv_dly);
         data_rdata_i  = (i == rv_dly) ? rdata : $urandom;
         @(negedge clk);
         chk("wait_req_low", data_req_o, 1'b0);
         chk("wait_stall", stall_o, 1'b1);
         chk("wait_rf_we", rf_we_o, 1'b0);
         next_cycle();
      end
      data_rvalid_i = 1'b0;
      data_rdata_i  = $urandom;
      @(negedge clk);
      chk("done_stall", stall_o, 1'b0);
      chk("done_req", data_req_o, 1'b0);
      chk("done_rf_we", rf_we_o, exp_rf_we);
      chk("done_bus_err", bus_error_o, 1'b0);
      if (exp_rf_we) begin
         chk("done_rf_wdata", rf_wdata_o, exp_rf_wdata);
         chk("done_rf_waddr", rf_waddr_o, wa);
      end
      next_cycle();
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{3'b000, 2'b00, 1'b1, 32'hDEADBEEF, 5'd7,  1'b1, 1'b0};
      vecs[1] = '{3'b000, 2'b00, 1'b0, 32'h12345678, 5'd3,  1'b0, 1'b0};
      vecs[2] = '{3'b100, 2'b00, 1'b1, 32'hCAFEF00D, 5'd31, 1'b1, 1'b0};
      vecs[3] = '{3'b111, 2'b00, 1'b1, 32'h00000101, 5'd1,  1'b1, 1'b0};
      vecs[4] = '{3'b011, 2'b00, 1'b1, 32'h00000101, 5'd4,  1'b0, 1'b1};
      vecs[5] = '{3'b010, 2'b00, 1'b1, 32'h00000203, 5'd5,  1'b0, 1'b1};
      vecs[6] = '{3'b110, 2'b00, 1'b1, 32'h00000201, 5'd6,  1'b0, 1'b1};
      vecs[7] = '{3'b000, 2'b10, 1'b1, 32'h00000001, 5'd8,  1'b0, 1'b1};
      vecs[8] = '{3'b000, 2'b11, 1'b1, 32'h00000002, 5'd9,  1'b0, 1'b1};
      vecs[9] = '{3'b001, 2'b11, 1'b1, 32'h00000003, 5'd10, 1'b0, 1'b1};

      rst           = 1'b1;
      data_gnt_i    = 1'b0;
      data_rvalid_i = 1'b0;
      data_rdata_i  = 32'h0;
      set_instr(3'b011, 2'b00, 1'b1, 32'h00000100, 32'h11223344, 5'd7);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_req", data_req_o, 1'b0);
      chk("rst_addr", data_addr_o, 32'h0);
      chk("rst_be", data_be_o, 4'h0);
      chk("rst_rf_we", rf_we_o, 1'b0);
      chk("rst_rf_wdata", rf_wdata_o, 32'h0);
      chk("rst_bus_err", bus_error_o, 1'b0);
      next_cycle();
      rst = 1'b0;

      // Single-cycle IDLE behaviour: pass-through and misaligned rejection.
      for (int i = 0; i < 10; i++) begin
         set_instr(vecs[i].lt, vecs[i].st, vecs[i].we, vecs[i].wbd, 32'h55AA55AA, vecs[i].wa);
         @(negedge clk);
         chk($sformatf("vec%0d_rf_we", i), rf_we_o, vecs[i].exp_rf_we);
         chk($sformatf("vec%0d_stall", i), stall_o, 1'b0);
         chk($sformatf("vec%0d_req", i), data_req_o, 1'b0);
         chk($sformatf("vec%0d_mis", i), misaligned_o, vecs[i].exp_mis);
         if (!vecs[i].exp_mis) begin
            chk($sformatf("vec%0d_rf_wdata", i), rf_wdata_o, vecs[i].wbd);
            chk($sformatf("vec%0d_rf_waddr", i), rf_waddr_o, vecs[i].wa);
         end
         next_cycle();
      end

      // Directed handshake sequences.
      mem_access(3'b001, 2'b00, 1'b1, 32'h00000103, 32'h0, 5'd5, 0, 2, 32'h80112233,
                 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFFFF80);
      mem_access(3'b101, 2'b00, 1'b1, 32'h00000103, 32'h0, 5'd6, 0, 2, 32'h80112233,
                 4'b1000, 32'h0, 1'b0, 1'b1, 32'h00000080);
      mem_access(3'b000, 2'b10, 1'b1, 32'h00000202, 32'h0000ABCD, 5'd2, 3, 1, 32'h0,
                 4'b1100, 32'hABCDABCD, 1'b1, 1'b0, 32'h0);
      mem_access(3'b010, 2'b00, 1'b1, 32'h00000002, 32'h0, 5'd11, 1, 1, 32'h9ABC1234,
                 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF9ABC);

      // Reset while waiting for the read response.
      set_instr(3'b011, 2'b00, 1'b1, 32'h00000100, 32'h0, 5'd12);
      data_gnt_i = 1'b1;
      next_cycle();
      data_gnt_i = 1'b0;
      @(negedge clk);
      chk("rw_wait_stall", stall_o, 1'b1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rw_rst_stall", stall_o, 1'b0);
      chk("rw_rst_req", data_req_o, 1'b0);
      chk("rw_rst_addr", data_addr_o, 32'h0);
      chk("rw_rst_rf_we", rf_we_o, 1'b0);
      chk("rw_rst_waddr", rf_waddr_o, 5'd0);
      next_cycle();
      rst = 1'b0;
      set_instr(3'b000, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
      data_rvalid_i = 1'b1;
      data_rdata_i  = 32'hFFFFFFFF;
      @(negedge clk);
      chk("rw_late_rf_we", rf_we_o, 1'b0);
      chk("rw_late_stall", stall_o, 1'b0);
      chk("rw_late_req", data_req_o, 1'b0);
      next_cycle();
      data_rvalid_i = 1'b0;
      set_instr(3'b000, 2'b00, 1'b1, 32'h13579BDF, 32'h0, 5'd9);
      @(negedge clk);
      chk("rw_idle_rf_we", rf_we_o, 1'b1);
      chk("rw_idle_rf_wdata", rf_wdata_o, 32'h13579BDF);
      chk("rw_idle_stall", stall_o, 1'b0);
      next_cycle();

`ifdef WB_MEM_TIMEOUT_EN
      // Grant never arrives: abort on the fourth cycle after issue.
      set_instr(3'b011, 2'b00, 1'b1, 32'h00000010, 32'h0, 5'd13);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         chk($sformatf("tmo_c%0d_bus_err", i), bus_error_o, (i == 4) ? 1'b1 : 1'b0);
         chk($sformatf("tmo_c%0d_req", i), data_req_o, (i == 4) ? 1'b0 : 1'b1);
         next_cycle();
      end
      @(negedge clk);
      chk("tmo_done_stall", stall_o, 1'b0);
      chk("tmo_done_rf_we", rf_we_o, 1'b0);
      chk("tmo_done_bus_err", bus_error_o, 1'b0);
      next_cycle();
      set_instr(3'b000, 2'b00, 1'b1, 32'h2468ACE0, 32'h0, 5'd14);
      @(negedge clk);
      chk("tmo_idle_rf_wdata", rf_wdata_o, 32'h2468ACE0);
      chk("tmo_idle_stall", stall_o, 1'b0);
      next_cycle();
`endif

      // Randomized instructions against the reference model.
      for (int t = 0; t < 120; t++) begin
         logic [2:0]  lt;
         logic [1:0]  st;
         logic        we;
         logic [31:0] addr;
         logic [31:0] sd;
         logic [31:0] rd;
         logic [4:0]  wa;
         int          n;
         int          gd;
         int          rv;
         logic        is_load;
         lt   = 3'($urandom_range(0, 7));
         st   = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
         we   = 1'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
         sd   = $urandom;
         rd   = $urandom;
         wa   = 5'($urandom_range(0, 31));
         gd   = $urandom_range(0, 3);
         rv   = $urandom_range(1, 3);
         if (rv > 1 && gd + rv > MAX_PEND) rv = 1;
         n       = m_size(lt, st);
         is_load = (n != 0) && (st == 2'b00);
         if (n == 0) begin
            set_instr(lt, st, we, addr, sd, wa);
            @(negedge clk);
            chk("rnd_alu_rf_we", rf_we_o, we);
            chk("rnd_alu_rf_wdata", rf_wdata_o, addr);
            chk("rnd_alu_rf_waddr", rf_waddr_o, wa);
            chk("rnd_alu_stall", stall_o, 1'b0);
            next_cycle();
         end else if ((addr % n) != 0) begin
            set_instr(lt, st, we, addr, sd, wa);
            @(negedge clk);
            chk("rnd_mis_pulse", misaligned_o, 1'b1);
            chk("rnd_mis_req", data_req_o, 1'b0);
            chk("rnd_mis_rf_we", rf_we_o, 1'b0);
            chk("rnd_mis_stall", stall_o, 1'b0);
            next_cycle();
         end else begin
            mem_access(lt, st, we, addr, sd, wa, gd, rv, rd,
                       m_be(n, addr), m_wdata(n, sd), !is_load,
                       is_load && we, m_load(n, (lt == 3'b001) || (lt == 3'b010), addr, rd));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
